// File: rtl/prio_encoder_arb.sv
// Registered N-input priority encoder / arbiter with a valid/ack result hold.
// The control is a two-state machine: IDLE (valid=0) and HELD (valid=1).
// A result is reloaded whenever it is not being held, which happens when the
// block is idle or when the consumer acks.
// In fixed mode the highest set bit wins. In round-robin mode the search runs
// downward from ptr-1 and wraps through N-1, so the source served last has the
// lowest priority on the next pick.
module prio_encoder_arb #(
  parameter int N  = 4,          // number of request inputs, 2..32
  parameter int RR = 0,          // 0 = fixed priority, 1 = round-robin
  parameter int W  = $clog2(N)   // derived index width; leave at default
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant,
  output logic [N-1:0] pending
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic         hold;
  logic         serve;
  logic         any_req;
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_eff;
  logic [W-1:0] start;
  logic         lo_found;
  logic [W-1:0] lo_idx;
  logic [W-1:0] hi_idx;
  logic [W-1:0] pick_idx;
  logic [N-1:0] pick_onehot;
  logic [N-1:0] grant_next;

  assign hold    = valid & ~ack;
  assign serve   = valid & ack;
  assign any_req = |req;

  // The pointer update and the reload share an edge on ack, so the pick that
  // reloads on ack must already see the just-served index as the pointer.
  assign ptr_eff = serve ? idx : ptr;

  // First index to search: ptr-1 (mod N) in round-robin mode, N-1 otherwise.
  always_comb begin
    start = LAST;
    if (RR != 0 && ptr_eff != '0) begin
      start = ptr_eff - W'(1);
    end
  end

  // Downward wrapping search split in two scans: the highest request at or
  // below start wins; if none exists, the highest request overall (which then
  // lies above start) is the first one reached after wrapping through N-1.
  // Indices are only ever produced from real bit positions, so values >= N
  // cannot appear for non-power-of-2 N.
  always_comb begin
    lo_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        hi_idx = W'(i);
        if (W'(i) <= start) begin
          lo_found = 1'b1;
          lo_idx   = W'(i);
        end
      end
    end
  end

  assign pick_idx    = lo_found ? lo_idx : hi_idx;
  assign pick_onehot = any_req ? (N'(1) << pick_idx) : '0;
  assign grant_next  = hold ? grant : pick_onehot;

  // Result register: frozen while held, otherwise reloaded from the current pick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= 1'b0;
      idx   <= '0;
      grant <= '0;
    end else if (!hold) begin
      valid <= any_req;
      idx   <= any_req ? pick_idx : '0;
      grant <= pick_onehot;
    end
  end

  // Round-robin pointer: records the served source whenever a result is consumed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (serve) begin
      ptr <= idx;
    end
  end

  // Pending requests: loaded every cycle so they line up with the grant they exclude.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= req & ~grant_next;
    end
  end

endmodule
